// File: rtl/ipv4_chksum_check_if.sv
// Header word stream into the RX IPv4 checksum checker and its result/field outputs.
// The master drives header words; the slave is the checker.
interface ipv4_chksum_check_if;
    logic        i_hdr_valid;
    logic        i_hdr_sop;
    logic [31:0] i_hdr_data;
    logic        o_hdr_ready;
    logic        o_chk_done;
    logic        o_chk_ok;
    logic        o_hdr_err;
    logic [15:0] o_ipv4_len;
    logic [7:0]  o_ipv4_ttl;
    logic [7:0]  o_ipv4_protocol;
    logic [31:0] o_ipv4_src_addr;
    logic [31:0] o_ipv4_dest_addr;

    modport master (
        output i_hdr_valid, i_hdr_sop, i_hdr_data,
        input  o_hdr_ready, o_chk_done, o_chk_ok, o_hdr_err, o_ipv4_len,
               o_ipv4_ttl, o_ipv4_protocol, o_ipv4_src_addr, o_ipv4_dest_addr
    );

    modport slave (
        input  i_hdr_valid, i_hdr_sop, i_hdr_data,
        output o_hdr_ready, o_chk_done, o_chk_ok, o_hdr_err, o_ipv4_len,
               o_ipv4_ttl, o_ipv4_protocol, o_ipv4_src_addr, o_ipv4_dest_addr
    );
endinterface

// File: rtl/ipv4_chksum_check.sv
// RX IPv4 header checksum checker: ones' complement sum of all header halves,
// carry folding, pass/fail flag and capture of the fields the parser needs.
module ipv4_chksum_check #(
    parameter int IPV4_CHKSUM_WIDTH = 16,
    parameter int ACC_EXTRA         = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    ipv4_chksum_check_if.slave   hdr
);
    localparam int W     = IPV4_CHKSUM_WIDTH;
    localparam int ACC_W = W + ACC_EXTRA;

    typedef enum logic [1:0] {IDLE, ACCUM, FOLD, DONE} state_t;

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [3:0]       ihl_reg, ihl_next;
    logic             err_reg, err_next;
    logic             ok_reg, ok_next;
    logic [15:0]      len_reg, len_next;
    logic [7:0]       ttl_reg, ttl_next;
    logic [7:0]       proto_reg, proto_next;
    logic [31:0]      src_reg, src_next;
    logic [31:0]      dst_reg, dst_next;

    logic [W-1:0]     half [2];
    logic [ACC_W-1:0] word_sum;
    logic             ready;
    logic             accept;
    logic             fmt_good;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half[gi] = hdr.i_hdr_data[gi*W +: W];
        end
    endgenerate

    assign word_sum = ACC_W'(half[0]) + ACC_W'(half[1]);
    assign ready    = (state_reg == IDLE) || (state_reg == ACCUM);
    assign accept   = hdr.i_hdr_valid & ready;
    assign fmt_good = (hdr.i_hdr_data[31:28] == 4'd4) && (hdr.i_hdr_data[27:24] >= 4'd5);

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ihl_next   = ihl_reg;
        err_next   = err_reg;
        ok_next    = ok_reg;
        len_next   = len_reg;
        ttl_next   = ttl_reg;
        proto_next = proto_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                // A sop word always (re)starts a header, abandoning any partial sum.
                if (accept && hdr.i_hdr_sop) begin
                    acc_next = word_sum;
                    ihl_next = hdr.i_hdr_data[27:24];
                    len_next = hdr.i_hdr_data[15:0];
                    cnt_next = 4'd1;
                    ok_next  = 1'b0;
                    if (fmt_good) begin
                        err_next   = 1'b0;
                        state_next = ACCUM;
                    end else begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end else if (accept && (state_reg == ACCUM)) begin
                    acc_next = acc_reg + word_sum;
                    cnt_next = cnt_reg + 4'd1;
                    case (cnt_reg)
                        4'd2: begin
                            ttl_next   = hdr.i_hdr_data[31:24];
                            proto_next = hdr.i_hdr_data[23:16];
                        end
                        4'd3:    src_next = hdr.i_hdr_data;
                        4'd4:    dst_next = hdr.i_hdr_data;
                        default: ;
                    endcase
                    if (cnt_reg == ihl_reg - 4'd1) begin
                        state_next = FOLD;
                    end
                end
            end
            FOLD: begin
                if (acc_reg[ACC_W-1:W] != '0) begin
                    acc_next = ACC_W'(acc_reg[W-1:0]) + ACC_W'(acc_reg[ACC_W-1:W]);
                end else begin
                    ok_next    = (acc_reg[W-1:0] == {W{1'b1}}) & ~err_reg;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ihl_reg   <= '0;
            err_reg   <= 1'b0;
            ok_reg    <= 1'b0;
            len_reg   <= '0;
            ttl_reg   <= '0;
            proto_reg <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ihl_reg   <= ihl_next;
            err_reg   <= err_next;
            ok_reg    <= ok_next;
            len_reg   <= len_next;
            ttl_reg   <= ttl_next;
            proto_reg <= proto_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
        end
    end

    assign hdr.o_hdr_ready      = ready;
    assign hdr.o_chk_done       = (state_reg == DONE);
    assign hdr.o_chk_ok         = ok_reg;
    assign hdr.o_hdr_err        = err_reg;
    assign hdr.o_ipv4_len       = len_reg;
    assign hdr.o_ipv4_ttl       = ttl_reg;
    assign hdr.o_ipv4_protocol  = proto_reg;
    assign hdr.o_ipv4_src_addr  = src_reg;
    assign hdr.o_ipv4_dest_addr = dst_reg;
endmodule

// File: tb/tb_ipv4_chksum_check.sv
// Scoreboard bench for ipv4_chksum_check: directed header cases plus random headers
// checked against a plain-arithmetic ones' complement model.
module tb_ipv4_chksum_check;
    typedef logic [31:0] hdr_t [16];

    typedef struct {
        logic        ok;
        logic        err;
        logic [15:0] len;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_done = 0;
    exp_t sb[$];

    logic [7:0]  m_ttl, m_proto;
    logic [31:0] m_src, m_dst;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ipv4_chksum_check_if bus ();

    ipv4_chksum_check dut (
        .clk (clk),
        .rst (rst),
        .hdr (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: sum every 16-bit half as a plain integer, then fold until it fits.
    function automatic logic [15:0] fold_sum(input hdr_t w, input int n, output int folds);
        int unsigned s = 0;
        for (int i = 0; i < n; i++) s += w[i][31:16] + w[i][15:0];
        folds = 0;
        while ((s >> 16) != 0) begin
            s = (s & 32'hFFFF) + (s >> 16);
            folds++;
        end
        return s[15:0];
    endfunction

    function automatic logic [15:0] chk_for(input hdr_t w, input int n);
        int f;
        w[2][15:0] = 16'h0000;
        return ~fold_sum(w, n, f);
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.o_chk_done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_done++;
                    check("ok",    32'(bus.o_chk_ok), 32'(e.ok));
                    check("err",   32'(bus.o_hdr_err), 32'(e.err));
                    check("len",   32'(bus.o_ipv4_len), 32'(e.len));
                    check("ttl",   32'(bus.o_ipv4_ttl), 32'(e.ttl));
                    check("proto", 32'(bus.o_ipv4_protocol), 32'(e.proto));
                    check("src",   bus.o_ipv4_src_addr, e.src);
                    check("dst",   bus.o_ipv4_dest_addr, e.dst);
                    check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                    $display("hdr %0d: ok=%0b err=%0b len=%h src=%h dst=%h lat=%0d",
                             n_done, bus.o_chk_ok, bus.o_hdr_err, bus.o_ipv4_len,
                             bus.o_ipv4_src_addr, bus.o_ipv4_dest_addr, cyc - e.acc_cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.o_hdr_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.o_hdr_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic put(input logic sop, input logic [31:0] d, input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) tick();
        wait_ready();
        bus.i_hdr_valid = 1'b1;
        bus.i_hdr_sop   = sop;
        bus.i_hdr_data  = d;
        tick();
        bus.i_hdr_valid = 1'b0;
        bus.i_hdr_sop   = 1'b0;
        bus.i_hdr_data  = $urandom;
    endtask

    task automatic junk_cycle();
        bus.i_hdr_valid = 1'b1;
        bus.i_hdr_sop   = 1'b0;
        bus.i_hdr_data  = $urandom;
        tick();
        bus.i_hdr_valid = 1'b0;
    endtask

    // Sends the first n_send words; a full header (or a malformed first word) yields an expectation.
    task automatic send_hdr(input hdr_t w, input int n_send, input bit gaps, input bit junk_fold);
        exp_t e;
        int   folds;
        int   ihl = int'(w[0][27:24]);
        bit   good = (w[0][31:28] == 4'd4) && (ihl >= 5);
        put(1'b1, w[0], gaps);
        if (!good) begin
            e.ok = 1'b0; e.err = 1'b1; e.len = w[0][15:0];
            e.ttl = m_ttl; e.proto = m_proto; e.src = m_src; e.dst = m_dst;
            e.lat = 0; e.acc_cyc = cyc;
            sb.push_back(e);
            repeat (4) junk_cycle();
            return;
        end
        for (int i = 1; i < n_send; i++) begin
            put(1'b0, w[i], gaps);
            if (i == 2) begin m_ttl = w[i][31:24]; m_proto = w[i][23:16]; end
            if (i == 3) m_src = w[i];
            if (i == 4) m_dst = w[i];
        end
        if (n_send == ihl) begin
            e.ok  = (fold_sum(w, ihl, folds) == 16'hFFFF);
            e.err = 1'b0; e.len = w[0][15:0];
            e.ttl = m_ttl; e.proto = m_proto; e.src = m_src; e.dst = m_dst;
            e.lat = 1 + folds; e.acc_cyc = cyc;
            sb.push_back(e);
            check("ready_low_after_last", 32'(bus.o_hdr_ready), 32'd0);
            if (junk_fold) junk_cycle();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        check("rst_ready", 32'(bus.o_hdr_ready), 32'd1);
        check("rst_done",  32'(bus.o_chk_done), 32'd0);
        check("rst_ok",    32'(bus.o_chk_ok), 32'd0);
        check("rst_err",   32'(bus.o_hdr_err), 32'd0);
        check("rst_len",   32'(bus.o_ipv4_len), 32'd0);
        check("rst_ttl",   32'({bus.o_ipv4_ttl, bus.o_ipv4_protocol}), 32'd0);
        check("rst_src",   bus.o_ipv4_src_addr, 32'd0);
        check("rst_dst",   bus.o_ipv4_dest_addr, 32'd0);
        m_ttl = '0; m_proto = '0; m_src = '0; m_dst = '0;
        rst = 1'b0;
    endtask

    initial begin
        hdr_t t1, t2, t3, t4, t6, r;
        int   ihl, n_send;
        bit   prev_complete;
        bus.i_hdr_valid = 1'b0;
        bus.i_hdr_sop   = 1'b0;
        bus.i_hdr_data  = '0;
        rst = 1'b1;
        tick();
        do_reset();

        t1 = '{default: 32'h0};
        t1[0] = 32'h45000073; t1[1] = 32'h00004000; t1[2] = 32'h4011B861;
        t1[3] = 32'hC0A80001; t1[4] = 32'hC0A800C7;
        send_hdr(t1, 5, 1'b0, 1'b0);

        t2 = t1;
        t2[2] = 32'h4011B862;
        send_hdr(t2, 5, 1'b0, 1'b0);

        t3 = '{default: 32'h0};
        t3[0] = 32'h46000020; t3[1] = 32'h12340000; t3[2] = 32'h40060000;
        t3[3] = 32'h0A000001; t3[4] = 32'h0A000002; t3[5] = 32'h01010000;
        t3[2][15:0] = chk_for(t3, 6);
        send_hdr(t3, 6, 1'b0, 1'b0);

        t4 = t1;
        t4[0] = 32'h65000073;
        send_hdr(t4, 5, 1'b0, 1'b0);

        // Abort after two words, then a complete header: only one done expected.
        send_hdr(t2, 2, 1'b0, 1'b0);
        send_hdr(t1, 5, 1'b0, 1'b0);

        // Reset during accumulation drops the partial header.
        send_hdr(t1, 3, 1'b0, 1'b0);
        do_reset();
        send_hdr(t1, 5, 1'b0, 1'b0);

        t6 = '{default: 32'hFFFFFFFF};
        t6[0] = 32'h4F00003C; t6[1] = 32'h00000000; t6[2] = 32'h40060000;
        t6[3] = 32'h0A000001; t6[4] = 32'h0A000002;
        t6[2][15:0] = chk_for(t6, 15);
        send_hdr(t6, 15, 1'b0, 1'b1);
        send_hdr(t2, 5, 1'b0, 1'b1);

        prev_complete = 1'b1;
        for (int k = 0; k < 200; k++) begin
            r = '{default: 32'h0};
            ihl = $urandom_range(5, 15);
            for (int i = 0; i < 16; i++) r[i] = $urandom;
            r[0][31:24] = {4'h4, 4'(ihl)};
            if ($urandom_range(0, 3) != 0) r[2][15:0] = chk_for(r, ihl);
            if ($urandom_range(0, 2) == 0) r[2][15:0] = 16'hFFFF;
            if ($urandom_range(0, 9) == 0) r[0][31:24] = 8'($urandom_range(0, 255));
            n_send = int'(r[0][27:24]);
            if (n_send < 5) n_send = 5;
            if ($urandom_range(0, 9) == 0) n_send = $urandom_range(1, n_send - 1);
            if (prev_complete && $urandom_range(0, 3) == 0) put(1'b0, $urandom, 1'b0);
            send_hdr(r, n_send, 1'b1, ($urandom_range(0, 1) == 1));
            prev_complete = (n_send == int'(r[0][27:24])) || (r[0][31:28] != 4'd4)
                            || (r[0][27:24] < 4'd5);
        end

        repeat (10) tick();
        check("pending_expectations", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
